frac_tick_gen: RTL and testbench

- Synthesizable fractional-period tick scheduler.
- Produces a one-cycle tick whose average period is cfg_int + cfg_frac/2^FRAC_W clk cycles, using a phase accumulator. This is the RTL analogue of fractional delays such as a 0.625-unit half-period.
- Sequences the clock-enable / strobe datapath used by high-speed interface models.
- Owns a start/stop state machine and a shadowed configuration handshake, so period changes land only on tick boundaries.

---
 rtl/frac_tick_gen.sv | 182 ++++++++++++++++++
 tb/tb_frac_tick_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : frac_tick_gen
// Purpose : Fractional-period tick scheduler using a phase accumulator, with a
//           start/stop sequencer and a shadowed configuration handshake.
// Revision: 1.0
// ============================================================================
module frac_tick_gen #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_err,
  input  logic              enable,
  output logic              tick,
  output logic              tgl_out,
  output logic              running,
  output logic [CNT_W-1:0]  tick_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [INT_W:0]      cnt_q,       cnt_d;
  logic [FRAC_W-1:0]   acc_q,       acc_d;
  logic                act_valid_q, act_valid_d;
  logic [INT_W-1:0]    act_int_q,   act_int_d;
  logic [FRAC_W-1:0]   act_frac_q,  act_frac_d;
  logic                pend_valid_q, pend_valid_d;
  logic [INT_W-1:0]    pend_int_q,  pend_int_d;
  logic [FRAC_W-1:0]   pend_frac_q, pend_frac_d;
  logic                tick_q,      tick_d;
  logic                tgl_q,       tgl_d;
  logic [CNT_W-1:0]    tick_cnt_q,  tick_cnt_d;
  logic                cfg_err_q,   cfg_err_d;

  logic                cfg_xfer;
  logic                cfg_legal;
  logic                at_edge;
  logic [INT_W-1:0]    sel_int;
  logic [FRAC_W-1:0]   sel_frac;
  logic [FRAC_W:0]     phase_sum;

  assign cfg_xfer  = cfg_valid && !pend_valid_q;
  assign cfg_legal = (cfg_int != '0);
  assign at_edge   = (state_q != ST_IDLE) && (cnt_q == (INT_W+1)'(1));

  // A waiting shadow config always wins for the next load of the counter.
  assign sel_int   = pend_valid_q ? pend_int_q  : act_int_q;
  assign sel_frac  = pend_valid_q ? pend_frac_q : act_frac_q;
  assign phase_sum = {1'b0, acc_q} + {1'b0, sel_frac};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    act_valid_d  = act_valid_q;
    act_int_d    = act_int_q;
    act_frac_d   = act_frac_q;
    pend_valid_d = pend_valid_q;
    pend_int_d   = pend_int_q;
    pend_frac_d  = pend_frac_q;
    tick_d       = 1'b0;
    tgl_d        = tgl_q;
    tick_cnt_d   = tick_cnt_q;
    cfg_err_d    = 1'b0;

    if (cfg_xfer) begin
      if (!cfg_legal) begin
        cfg_err_d = 1'b1;
      end else if (state_q == ST_IDLE) begin
        act_valid_d = 1'b1;
        act_int_d   = cfg_int;
        act_frac_d  = cfg_frac;
      end else begin
        pend_valid_d = 1'b1;
        pend_int_d   = cfg_int;
        pend_frac_d  = cfg_frac;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // A config parked at the final stop tick is promoted here.
        if (pend_valid_q) begin
          act_valid_d  = 1'b1;
          act_int_d    = pend_int_q;
          act_frac_d   = pend_frac_q;
          pend_valid_d = 1'b0;
        end
        if (enable && (act_valid_q || pend_valid_q)) begin
          state_d = ST_RUN;
          cnt_d   = {1'b0, sel_int};
          acc_d   = '0;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (at_edge) begin
          tick_d     = 1'b1;
          tgl_d      = ~tgl_q;
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
          acc_d      = phase_sum[FRAC_W-1:0];
          cnt_d      = {1'b0, sel_int} + {{INT_W{1'b0}}, phase_sum[FRAC_W]};
          if (pend_valid_q) begin
            act_valid_d  = 1'b1;
            act_int_d    = pend_int_q;
            act_frac_d   = pend_frac_q;
            pend_valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - (INT_W+1)'(1);
        end

        if (state_q == ST_RUN) begin
          if (!enable) begin
            state_d = ST_STOPPING;
          end
        end else if (enable) begin
          state_d = ST_RUN;
        end else if (at_edge) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      act_valid_q  <= 1'b0;
      act_int_q    <= '0;
      act_frac_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_int_q   <= '0;
      pend_frac_q  <= '0;
      tick_q       <= 1'b0;
      tgl_q        <= 1'b0;
      tick_cnt_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      act_valid_q  <= act_valid_d;
      act_int_q    <= act_int_d;
      act_frac_q   <= act_frac_d;
      pend_valid_q <= pend_valid_d;
      pend_int_q   <= pend_int_d;
      pend_frac_q  <= pend_frac_d;
      tick_q       <= tick_d;
      tgl_q        <= tgl_d;
      tick_cnt_q   <= tick_cnt_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_valid_q;
  assign cfg_err   = cfg_err_q;
  assign tick      = tick_q;
  assign tgl_out   = tgl_q;
  assign running   = (state_q != ST_IDLE);
  assign tick_cnt  = tick_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_frac_tick_gen
// Purpose : Directed bench for frac_tick_gen with a tick-time reference model.
// Revision: 1.0
// ============================================================================
module tb_frac_tick_gen;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_err;
  logic              enable;
  logic              tick;
  logic              tgl_out;
  logic              running;
  logic [CNT_W-1:0]  tick_cnt;

  frac_tick_gen #(.INT_W(INT_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_err(cfg_err),
    .enable(enable), .tick(tick), .tgl_out(tgl_out),
    .running(running), .tick_cnt(tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: ticks are scheduled as absolute cycle numbers; the
  // fractional remainder carries into the next interval as whole cycles.
  bit m_live, m_run, m_stop, m_av, m_pv;
  int m_ai, m_af, m_pi, m_pf, m_next, m_phase;
  bit e_tick, e_tgl, e_err;
  int e_cnt;
  bit o_av, o_pv, fire;
  int o_ai, o_af, o_pi, o_pf, r_int, r_frac, s;

  initial begin
    m_live = 0; m_run = 0; m_stop = 0; m_av = 0; m_pv = 0;
    m_ai = 0; m_af = 0; m_pi = 0; m_pf = 0; m_next = 0; m_phase = 0;
    e_tick = 0; e_tgl = 0; e_err = 0; e_cnt = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_live = 1; m_run = 0; m_stop = 0; m_av = 0; m_pv = 0;
        m_phase = 0; e_tick = 0; e_tgl = 0; e_err = 0; e_cnt = 0;
      end else begin
        o_av = m_av; o_ai = m_ai; o_af = m_af;
        o_pv = m_pv; o_pi = m_pi; o_pf = m_pf;
        e_tick = 0; e_err = 0;
        if (cfg_valid && !o_pv) begin
          if (cfg_int == 0) e_err = 1;
          else if (!m_run) begin m_av = 1; m_ai = cfg_int; m_af = cfg_frac; end
          else begin m_pv = 1; m_pi = cfg_int; m_pf = cfg_frac; end
        end
        if (!m_run) begin
          if (o_pv) begin m_av = 1; m_ai = o_pi; m_af = o_pf; m_pv = 0; end
          if (enable && (o_av || o_pv)) begin
            m_run = 1; m_stop = 0; m_phase = 0;
            m_next = cyc + (o_pv ? o_pi : o_ai);
          end
        end else begin
          fire = (cyc == m_next);
          if (fire) begin
            r_int  = o_pv ? o_pi : o_ai;
            r_frac = o_pv ? o_pf : o_af;
            if (o_pv) begin m_av = 1; m_ai = o_pi; m_af = o_pf; m_pv = 0; end
            e_tick = 1; e_tgl = !e_tgl; e_cnt = (e_cnt + 1) % (1 << CNT_W);
            s = m_phase + r_frac;
            m_next  = cyc + r_int + s / (1 << FRAC_W);
            m_phase = s % (1 << FRAC_W);
          end
          if (!m_stop) m_stop = !enable;
          else if (enable) m_stop = 0;
          else if (fire) begin m_run = 0; m_stop = 0; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("cmp_tick",      tick,      e_tick);
        check("cmp_tgl_out",   tgl_out,   e_tgl);
        check("cmp_running",   running,   m_run);
        check("cmp_tick_cnt",  tick_cnt,  e_cnt);
        check("cmp_cfg_err",   cfg_err,   e_err);
        check("cmp_cfg_ready", cfg_ready, !m_pv);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic offer(input int i, input int f);
    cfg_valid = 1'b1; cfg_int = INT_W'(i); cfg_frac = FRAC_W'(f);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int budget, output int t);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (tick !== 1'b1 && k < budget);
    if (tick !== 1'b1) begin
      n_total++;
      $display("FAIL tick_timeout: tick stayed %b for %0d cycles, required 1", tick, budget);
    end
    t = cyc;
  endtask

  task automatic wait_run(input int budget, output int t);
    int k;
    k = 0;
    while (running !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    if (running !== 1'b1) begin
      n_total++;
      $display("FAIL run_timeout: running stayed %b for %0d cycles, required 1", running, budget);
    end
    t = cyc;
  endtask

  int c0, a, t0, t1, t2, ta, tb, tc, prev, nt;
  int tq[$];
  int exp_frac[9] = '{2, 2, 3, 2, 3, 2, 3, 2, 3};

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_int = '0; cfg_frac = '0; enable = 1'b0;

    // Reset state and integer period with a slipped start.
    do_reset();
    check("rst_tick", tick, 0);
    check("rst_running", running, 0);
    check("rst_tick_cnt", tick_cnt, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_tgl", tgl_out, 0);
    check("rst_cfg_err", cfg_err, 0);
    enable = 1'b1;
    offer(3, 0);
    a = cyc;
    check("slip_running", running, 0);
    wait_run(5, c0);
    check("slip_delay", c0 - a, 1);
    tq.delete();
    repeat (30) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        tq.push_back(cyc);
        check("int_tgl", tgl_out, tq.size() % 2);
      end
    end
    check("int_tick_cnt_30", tick_cnt, 10);
    check("int_ticks_seen", tq.size(), 10);
    if (tq.size() > 0) check("int_first_tick", tq[0] - c0, 3);
    for (int i = 1; i < tq.size(); i++) check("int_period", tq[i] - tq[i-1], 3);

    // Fractional period 2.5 cycles.
    do_reset();
    offer(2, 'h80);
    enable = 1'b1;
    wait_run(5, c0);
    prev = c0;
    for (int i = 0; i < 9; i++) begin
      wait_tick(6, t1);
      check("frac_interval", t1 - prev, exp_frac[i]);
      if (i == 0) ta = t1;
      prev = t1;
    end
    check("frac_span_1_to_9", prev - ta, 20);

    // Mid-run reconfiguration, second offer while pending, illegal config.
    do_reset();
    offer(4, 0);
    enable = 1'b1;
    wait_run(5, c0);
    wait_tick(8, t0);
    check("recfg_first", t0 - c0, 4);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_int = 16'd6; cfg_frac = 8'd0;
    @(negedge clk);
    check("recfg_ready_low", cfg_ready, 0);
    cfg_int = 16'd9;
    @(negedge clk);
    check("recfg_ready_low2", cfg_ready, 0);
    cfg_valid = 1'b0;
    wait_tick(8, ta);
    check("recfg_old_period", ta - t0, 4);
    check("recfg_ready_back", cfg_ready, 1);
    wait_tick(10, tb);
    check("recfg_new_period", tb - ta, 6);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_int = 16'd0; cfg_frac = 8'h10;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("illegal_err", cfg_err, 1);
    check("illegal_ready", cfg_ready, 1);
    @(negedge clk);
    check("illegal_err_pulse", cfg_err, 0);
    wait_tick(10, tc);
    check("illegal_period_kept", tc - tb, 6);
    wait_tick(10, t1);
    check("second_offer_dropped", t1 - tc, 6);

    // Graceful stop after the third tick.
    do_reset();
    offer(5, 0);
    enable = 1'b1;
    wait_run(5, c0);
    wait_tick(8, ta);
    wait_tick(8, t0);
    @(negedge clk);
    enable = 1'b0;
    wait_tick(8, t1);
    check("stop_last_tick", t1 - t0, 5);
    check("stop_running", running, 0);
    check("stop_tgl", tgl_out, 1);
    nt = 0;
    repeat (8) begin
      @(negedge clk);
      if (tick === 1'b1) nt++;
    end
    check("stop_no_more_ticks", nt, 0);
    check("stop_tgl_held", tgl_out, 1);
    check("stop_tick_cnt", tick_cnt, 3);

    // Re-enable during STOPPING, then reset just before a tick.
    do_reset();
    offer(5, 0);
    enable = 1'b1;
    wait_run(5, c0);
    wait_tick(8, t0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("stopping_running", running, 1);
    enable = 1'b1;
    wait_tick(8, t1);
    check("resume_period", t1 - t0, 5);
    wait_tick(8, t2);
    check("resume_period2", t2 - t1, 5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tick", tick, 0);
    check("midrst_running", running, 0);
    check("midrst_tgl", tgl_out, 0);
    check("midrst_tick_cnt", tick_cnt, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("enable_no_cfg", running, 0);

    // Minimum period and tick counter wrap.
    offer(1, 0);
    wait_run(5, c0);
    prev = c0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(3, t1);
      check("min_period", t1 - prev, 1);
      check("min_tgl", tgl_out, (i + 1) % 2);
      if (i == 14) check("wrap_cnt_15", tick_cnt, 15);
      if (i == 15) check("wrap_cnt_0", tick_cnt, 0);
      prev = t1;
    end
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
